// File: rtl/otter_bp_pkg.sv
// Shared types for the branch target buffer: counter encoding, per-entry
// status record and the counter value entries take after reset.
package otter_bp_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    // Status half of a BTB entry; tag and target live in parallel non-reset arrays.
    typedef struct packed {
        logic valid;
        ctr_t ctr;
    } btb_entry_t;

    localparam ctr_t CTR_RESET = CTR_WNT;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter; jumps pin it to strong-taken.
module sat_counter2
    import otter_bp_pkg::*;
(
    input  ctr_t ctr_i,
    input  logic taken_i,
    input  logic jump_i,
    output ctr_t ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (jump_i) begin
            ctr_o = CTR_ST;
        end else if (taken_i) begin
            case (ctr_i)
                CTR_SNT: ctr_o = CTR_WNT;
                CTR_WNT: ctr_o = CTR_WT;
                CTR_WT:  ctr_o = CTR_ST;
                CTR_ST:  ctr_o = CTR_ST;
            endcase
        end else begin
            case (ctr_i)
                CTR_SNT: ctr_o = CTR_SNT;
                CTR_WNT: ctr_o = CTR_SNT;
                CTR_WT:  ctr_o = CTR_WNT;
                CTR_ST:  ctr_o = CTR_WT;
            endcase
        end
    end

endmodule

// File: rtl/branch_target_unit.sv
// Direct-mapped branch target buffer with 2-bit direction counters, plus the
// execute-stage target adder and mispredict detection.
module branch_target_unit
    import otter_bp_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 16
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [XLEN-1:0] PCF,
    output logic            HitF,
    output logic            PredTakenF,
    output logic [XLEN-1:0] PredTargetF,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic            JalrE,
    input  logic            UpdateE,
    input  logic            TakenE,
    input  logic            JumpE,
    input  logic            PredTakenE,
    input  logic [XLEN-1:0] PredTargetE,
    input  logic            FlushBTB,
    output logic [XLEN-1:0] PCTargetE,
    output logic            MispredictE
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    btb_entry_t       state_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] e_tag;
    logic             e_hit;
    ctr_t             ctr_cur;
    ctr_t             ctr_d;
    logic             upd_we;
    logic             tgt_we;

    // Fetch-side lookup
    assign f_idx       = PCF[IDX_W+1:2];
    assign f_tag       = PCF[XLEN-1:IDX_W+2];
    assign HitF        = state_q[f_idx].valid && (tag_q[f_idx] == f_tag);
    assign PredTakenF  = HitF && state_q[f_idx].ctr[1];
    assign PredTargetF = PredTakenF ? target_q[f_idx] : PCF + XLEN'(4);

    // Execute-side target and redirect
    assign PCTargetE   = JalrE ? ((SrcAE + ImmExtE) & ~XLEN'(1)) : (PCE + ImmExtE);
    assign MispredictE = UpdateE && ((TakenE != PredTakenE) ||
                                     (TakenE && (PredTargetE != PCTargetE)));

    assign e_idx = PCE[IDX_W+1:2];
    assign e_tag = PCE[XLEN-1:IDX_W+2];
    assign e_hit = state_q[e_idx].valid && (tag_q[e_idx] == e_tag);

    // A fresh allocation steps from weak-NT, so a taken outcome lands on weak-T.
    assign ctr_cur = e_hit ? state_q[e_idx].ctr : CTR_WNT;

    sat_counter2 u_ctr (
        .ctr_i   (ctr_cur),
        .taken_i (TakenE),
        .jump_i  (JumpE),
        .ctr_o   (ctr_d)
    );

    assign upd_we = UpdateE && !FlushBTB && (e_hit || TakenE);
    assign tgt_we = UpdateE && !FlushBTB && TakenE;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                state_q[i] <= '{valid: 1'b0, ctr: CTR_RESET};
            end
        end else if (FlushBTB) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                state_q[i].valid <= 1'b0;
            end
        end else if (upd_we) begin
            state_q[e_idx] <= '{valid: 1'b1, ctr: ctr_d};
        end
    end

    // Tag/target writes during reset are harmless: the entry stays invalid.
    always_ff @(posedge CLK) begin
        if (tgt_we) begin
            tag_q[e_idx]    <= e_tag;
            target_q[e_idx] <= PCTargetE;
        end
    end

endmodule

// File: tb/tb_branch_target_unit.sv
// Directed bench for branch_target_unit: a vector table applied one cycle per
// entry, then hand-written reset-during-update sequences.
module tb_branch_target_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] PCF, PCE, ImmExtE, SrcAE, PredTargetE;
    logic        JalrE, UpdateE, TakenE, JumpE, PredTakenE, FlushBTB;
    logic        HitF, PredTakenF, MispredictE;
    logic [31:0] PredTargetF, PCTargetE;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    branch_target_unit #(.XLEN(32), .ENTRIES(16)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .PCF         (PCF),
        .HitF        (HitF),
        .PredTakenF  (PredTakenF),
        .PredTargetF (PredTargetF),
        .PCE         (PCE),
        .ImmExtE     (ImmExtE),
        .SrcAE       (SrcAE),
        .JalrE       (JalrE),
        .UpdateE     (UpdateE),
        .TakenE      (TakenE),
        .JumpE       (JumpE),
        .PredTakenE  (PredTakenE),
        .PredTargetE (PredTargetE),
        .FlushBTB    (FlushBTB),
        .PCTargetE   (PCTargetE),
        .MispredictE (MispredictE)
    );

    typedef struct {
        logic [31:0] pcf;
        logic        upd, taken, jump, jalr, flush;
        logic [31:0] pce, imm, srca;
        logic        ptk_e;
        logic [31:0] ptg_e;
        logic        e_hit, e_ptk;
        logic [31:0] e_ptg, e_tgt;
        logic        e_mis;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    function automatic vec_t v(
        input logic [31:0] pcf, input logic upd, input logic taken, input logic jump,
        input logic jalr, input logic flush, input logic [31:0] pce, input logic [31:0] imm,
        input logic [31:0] srca, input logic ptk_e, input logic [31:0] ptg_e,
        input logic e_hit, input logic e_ptk, input logic [31:0] e_ptg,
        input logic [31:0] e_tgt, input logic e_mis);
        vec_t r;
        r.pcf = pcf; r.upd = upd; r.taken = taken; r.jump = jump; r.jalr = jalr;
        r.flush = flush; r.pce = pce; r.imm = imm; r.srca = srca; r.ptk_e = ptk_e;
        r.ptg_e = ptg_e; r.e_hit = e_hit; r.e_ptk = e_ptk; r.e_ptg = e_ptg;
        r.e_tgt = e_tgt; r.e_mis = e_mis;
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        PCF = x.pcf; UpdateE = x.upd; TakenE = x.taken; JumpE = x.jump;
        JalrE = x.jalr; FlushBTB = x.flush; PCE = x.pce; ImmExtE = x.imm;
        SrcAE = x.srca; PredTakenE = x.ptk_e; PredTargetE = x.ptg_e;
    endtask

    task automatic idle();
        PCF = '0; UpdateE = 1'b0; TakenE = 1'b0; JumpE = 1'b0; JalrE = 1'b0;
        FlushBTB = 1'b0; PCE = '0; ImmExtE = '0; SrcAE = '0; PredTakenE = 1'b0;
        PredTargetE = '0;
    endtask

    initial begin
        //            pcf          upd tk jp jr fl pce          imm          srca     ptkE ptgE     hit ptk ptg          tgt          mis
        vecs[0]  = v(32'h100,      0, 0, 0, 0, 0, 32'h0,       32'h0,       32'h0,    0, 32'h0,     0, 0, 32'h104,     32'h0,       0);
        vecs[1]  = v(32'h100,      1, 1, 0, 0, 0, 32'h100,     32'h40,      32'h0,    0, 32'h0,     0, 0, 32'h104,     32'h140,     1);
        vecs[2]  = v(32'h100,      0, 0, 0, 0, 0, 32'h100,     32'h40,      32'h0,    0, 32'h0,     1, 1, 32'h140,     32'h140,     0);
        vecs[3]  = v(32'h100,      1, 1, 1, 1, 0, 32'h204,     32'h4,       32'h2003, 1, 32'h2000,  1, 1, 32'h140,     32'h2006,    1);
        vecs[4]  = v(32'h204,      0, 0, 0, 0, 0, 32'h0,       32'h0,       32'h0,    0, 32'h0,     1, 1, 32'h2006,    32'h0,       0);
        vecs[5]  = v(32'h100,      1, 0, 0, 0, 0, 32'h100,     32'h40,      32'h0,    1, 32'h140,   1, 1, 32'h140,     32'h140,     1);
        vecs[6]  = v(32'h100,      1, 0, 0, 0, 0, 32'h100,     32'h40,      32'h0,    1, 32'h140,   1, 0, 32'h104,     32'h140,     1);
        vecs[7]  = v(32'h100,      1, 0, 0, 0, 0, 32'h100,     32'h40,      32'h0,    1, 32'h140,   1, 0, 32'h104,     32'h140,     1);
        vecs[8]  = v(32'h100,      1, 0, 0, 0, 0, 32'h100,     32'h40,      32'h0,    1, 32'h140,   1, 0, 32'h104,     32'h140,     1);
        vecs[9]  = v(32'h100,      0, 0, 0, 0, 0, 32'h0,       32'h0,       32'h0,    0, 32'h0,     1, 0, 32'h104,     32'h0,       0);
        vecs[10] = v(32'h100,      1, 1, 0, 0, 0, 32'h100,     32'h80,      32'h0,    0, 32'h0,     1, 0, 32'h104,     32'h180,     1);
        vecs[11] = v(32'h100,      1, 1, 0, 0, 0, 32'h100,     32'h80,      32'h0,    1, 32'h180,   1, 0, 32'h104,     32'h180,     0);
        vecs[12] = v(32'h100,      0, 0, 0, 0, 0, 32'h0,       32'h0,       32'h0,    0, 32'h0,     1, 1, 32'h180,     32'h0,       0);
        vecs[13] = v(32'h100,      1, 1, 0, 0, 0, 32'h100,     32'h80,      32'h0,    1, 32'h184,   1, 1, 32'h180,     32'h180,     1);
        vecs[14] = v(32'h308,      1, 0, 0, 0, 0, 32'h308,     32'h10,      32'h0,    0, 32'h0,     0, 0, 32'h30c,     32'h318,     0);
        vecs[15] = v(32'h308,      0, 0, 0, 0, 0, 32'h0,       32'h0,       32'h0,    0, 32'h0,     0, 0, 32'h30c,     32'h0,       0);
        vecs[16] = v(32'h100,      1, 1, 0, 0, 0, 32'h140,     32'h20,      32'h0,    0, 32'h0,     1, 1, 32'h180,     32'h160,     1);
        vecs[17] = v(32'h100,      0, 0, 0, 0, 0, 32'h0,       32'h0,       32'h0,    0, 32'h0,     0, 0, 32'h104,     32'h0,       0);
        vecs[18] = v(32'h140,      0, 0, 0, 0, 0, 32'h0,       32'h0,       32'h0,    0, 32'h0,     1, 1, 32'h160,     32'h0,       0);
        vecs[19] = v(32'h204,      0, 1, 0, 0, 0, 32'h140,     32'h20,      32'h0,    0, 32'h0,     1, 1, 32'h2006,    32'h160,     0);
        vecs[20] = v(32'h204,      1, 1, 0, 0, 1, 32'h308,     32'h10,      32'h0,    0, 32'h0,     1, 1, 32'h2006,    32'h318,     1);
        vecs[21] = v(32'h204,      0, 0, 0, 0, 0, 32'h0,       32'h0,       32'h0,    0, 32'h0,     0, 0, 32'h208,     32'h0,       0);
        vecs[22] = v(32'h308,      0, 0, 0, 0, 0, 32'h0,       32'h0,       32'h0,    0, 32'h0,     0, 0, 32'h30c,     32'h0,       0);
        vecs[23] = v(32'h140,      0, 0, 0, 0, 0, 32'h0,       32'h0,       32'h0,    0, 32'h0,     0, 0, 32'h144,     32'h0,       0);
        vecs[24] = v(32'hFFFFFFFC, 0, 0, 0, 0, 0, 32'hFFFFFFF0, 32'h20,      32'h0,    0, 32'h0,     0, 0, 32'h0,       32'h10,      0);
        vecs[25] = v(32'h0,        0, 0, 0, 1, 0, 32'h0,       32'hFFFFFFFF, 32'h1000, 0, 32'h0,     0, 0, 32'h4,       32'hFFE,     0);

        idle();
        RST_N = 1'b0;
        PCF   = 32'h100;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_hit", 0, 32'(HitF), 32'h0);
        check("rst_ptk", 0, 32'(PredTakenF), 32'h0);
        check("rst_ptg", 0, PredTargetF, 32'h104);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            @(negedge CLK);
            check("hit", i, 32'(HitF), 32'(vecs[i].e_hit));
            check("ptk", i, 32'(PredTakenF), 32'(vecs[i].e_ptk));
            check("ptg", i, PredTargetF, vecs[i].e_ptg);
            check("tgt", i, PCTargetE, vecs[i].e_tgt);
            check("mis", i, 32'(MispredictE), 32'(vecs[i].e_mis));
            @(posedge CLK);
            #1;
        end

        // Allocate 0x100, then drop reset mid-cycle while an update is pending.
        idle();
        UpdateE = 1'b1; TakenE = 1'b1; PCE = 32'h100; ImmExtE = 32'h40;
        @(posedge CLK);
        #1;
        idle();
        PCF = 32'h100;
        #1;
        check("seq_hit_pre", 0, 32'(HitF), 32'h1);
        check("seq_ptg_pre", 0, PredTargetF, 32'h140);

        UpdateE = 1'b1; TakenE = 1'b1; PCE = 32'h308; ImmExtE = 32'h10;
        RST_N = 1'b0;
        #1;
        check("seq_rst_hit", 0, 32'(HitF), 32'h0);
        check("seq_rst_ptg", 0, PredTargetF, 32'h104);
        check("seq_rst_tgt", 0, PCTargetE, 32'h318);
        check("seq_rst_mis", 0, 32'(MispredictE), 32'h1);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        PCE = 32'h204; ImmExtE = 32'h10;
        @(posedge CLK);
        #1;
        idle();
        PCF = 32'h308;
        #1;
        check("seq_disc_hit", 0, 32'(HitF), 32'h0);
        PCF = 32'h100;
        #1;
        check("seq_old_hit", 0, 32'(HitF), 32'h0);
        PCF = 32'h204;
        #1;
        check("seq_new_hit", 0, 32'(HitF), 32'h1);
        check("seq_new_ptk", 0, 32'(PredTakenF), 32'h1);
        check("seq_new_ptg", 0, PredTargetF, 32'h214);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_target_unit.md
BRANCH_TARGET_UNIT -- requirements
Module: branch_target_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning address/data width.
REQ-002 The block SHALL have parameter ENTRIES, default 16, meaning BTB entry count (power of two, 4..256); IDX_W = log2(ENTRIES); TAG_W = XLEN-IDX_W-2.
REQ-003 The block SHALL have port CLK, input, 1 bit: sole clock, rising edge.
REQ-004 The block SHALL have port RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port PCF, input, XLEN bits: fetch-stage PC, used for lookup.
REQ-006 The block SHALL have port HitF, output, 1 bit: valid entry with matching tag for PCF.
REQ-007 The block SHALL have port PredTakenF, output, 1 bit: predicted taken.
REQ-008 The block SHALL have port PredTargetF, output, XLEN bits: predicted next PC.
REQ-009 The block SHALL have port PCE, input, XLEN bits: execute-stage PC.
REQ-010 The block SHALL have port ImmExtE, input, XLEN bits: extended immediate.
REQ-011 The block SHALL have port SrcAE, input, XLEN bits: rs1 value for JALR.
REQ-012 The block SHALL have port JalrE, input, 1 bit: target base select (1 = SrcAE, 0 = PCE).
REQ-013 The block SHALL have port UpdateE, input, 1 bit: resolved branch/jump in execute this cycle.
REQ-014 The block SHALL have port TakenE, input, 1 bit: actual outcome.
REQ-015 The block SHALL have port JumpE, input, 1 bit: unconditional jump (JAL/JALR).
REQ-016 The block SHALL have ports PredTakenE and PredTargetE, inputs, 1 and XLEN bits: prediction carried down the pipeline.
REQ-017 The block SHALL have port FlushBTB, input, 1 bit: invalidate all entries.
REQ-018 The block SHALL have port PCTargetE, output, XLEN bits: computed target.
REQ-019 The block SHALL have port MispredictE, output, 1 bit: redirect request.

Function
REQ-020 PCTargetE SHALL be combinational: JalrE=0 -> PCE+ImmExtE; JalrE=1 -> (SrcAE+ImmExtE) with bit 0 cleared; modulo 2^XLEN, wrap-around ignored.
REQ-021 Lookup index SHALL be PCF[IDX_W+1:2] and tag SHALL be PCF[XLEN-1:IDX_W+2]; HitF SHALL be combinational from registered entry state.
REQ-022 PredTakenF SHALL be HitF AND counter[1]; PredTargetF SHALL be the stored target when PredTakenF=1, else PCF+4.
REQ-023 Each entry SHALL hold valid, tag, target and a 2-bit saturating counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
REQ-024 On UpdateE with a hit at PCE, the counter SHALL increment on TakenE and decrement otherwise, saturating at 11/00, and the target SHALL be written with PCTargetE when TakenE=1.
REQ-025 On UpdateE with a miss and TakenE=1, the entry SHALL be allocated (overwriting): valid=1, tag, target=PCTargetE, counter=10.
REQ-026 On UpdateE with a miss and TakenE=0, no entry SHALL change.
REQ-027 On UpdateE with JumpE=1, the counter SHALL be forced to 11.
REQ-028 MispredictE SHALL be UpdateE AND ((TakenE != PredTakenE) OR (TakenE AND PredTargetE != PCTargetE)), combinational.
REQ-029 Update writes SHALL take effect at the next CLK edge; a same-cycle lookup of the updated index SHALL return pre-update contents.
REQ-030 FlushBTB SHALL clear all valid bits at the next edge and SHALL take priority over a simultaneous update; counters and targets SHALL be left unchanged.
REQ-031 With UpdateE=0, only FlushBTB SHALL alter state.

Reset
REQ-032 RST_N low SHALL asynchronously clear all valid bits and set all counters to 01; tags and targets SHALL not require reset.
REQ-033 During reset, HitF=0, PredTakenF=0 and PredTargetF=PCF+4; PCTargetE and MispredictE SHALL remain combinational.
REQ-034 Reset asserted mid-update SHALL discard the update; the first edge after release SHALL behave as normal.

Structure
REQ-035 Shared package otter_bp_pkg SHALL hold the counter encoding typedef, the entry struct and the reset counter constant.
REQ-036 The 2-bit counter SHALL be a sub-module sat_counter2 (next-state function) instantiated once in the update path.

Verification
REQ-037 Reset then lookup of PCF=0x100 -> HitF=0, PredTargetF=0x104.
REQ-038 UpdateE, PCE=0x100, ImmExtE=0x40, TakenE=1 -> PCTargetE=0x140; next cycle PCF=0x100 -> HitF=1, PredTakenF=1, PredTargetF=0x140.
REQ-039 JalrE=1, SrcAE=0x2003, ImmExtE=0x4 -> PCTargetE=0x2006; with PredTakenE=1, PredTargetE=0x2000 -> MispredictE=1.
REQ-040 Four not-taken updates at a hit entry -> counter reaches 00 and stays there; the next lookup gives PredTakenF=0.
REQ-041 Aliasing: entry for 0x100 allocated, then taken update at 0x100+4*ENTRIES -> old tag is replaced and lookup of 0x100 misses.
REQ-042 FlushBTB with a simultaneous taken UpdateE -> all entries invalid the next cycle; asserting RST_N low mid-operation -> HitF=0 immediately.
